// File: rtl/ecg_pkg.sv
// Shared types and constants for the ECG sample writer and its bank RAM.
package ecg_pkg;

    localparam int ECG_SAMPLE_W = 8;
    localparam int ECG_DEPTH    = 256;

    typedef logic [ECG_SAMPLE_W-1:0] ecg_sample_t;

    localparam ecg_sample_t ECG_MIDLINE = 8'h80;

    typedef enum logic {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } wr_state_t;

endpackage

// File: rtl/ecg_bank_ram.sv
// Two-bank sample store: one write port, one registered read port, addressed by {bank, addr}.
module ecg_bank_ram
    import ecg_pkg::*;
#(
    parameter int unsigned DEPTH  = ECG_DEPTH,
    parameter int unsigned DATA_W = ECG_SAMPLE_W
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(2*DEPTH)-1:0]    waddr,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [$clog2(2*DEPTH)-1:0]    raddr,
    output logic [DATA_W-1:0]             rdata
);

    logic [DATA_W-1:0] mem [2*DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ecg_sample_writer.sv
// Double-buffered ECG sample writer: fills the back bank, swaps it to the display at frame_start.
// Optional build macro ECG_PAIR_AVG_EN stores the rounded mean of each input pair.
module ecg_sample_writer
    import ecg_pkg::*;
#(
    parameter int unsigned DEPTH          = ECG_DEPTH,
    parameter bit          DROP_WHEN_FULL = 1'b0,
    parameter ecg_sample_t MIDLINE        = ECG_MIDLINE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  ecg_sample_t              in_data,
    input  logic                     frame_start,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output ecg_sample_t              rd_data,
    output logic                     front_bank,
    output logic                     frame_valid,
    output logic                     swap_pulse,
    output logic [15:0]              overrun_cnt
);

    localparam int AW = $clog2(DEPTH);

    wr_state_t         state_q;
    wr_state_t         state_d;
    logic [AW-1:0]     ptr_q;
    logic              front_bank_q;
    logic              frame_valid_q;
    logic              swap_pulse_q;
    logic [15:0]       overrun_q;
    logic              accept;
    logic              store;
    logic              drop;
    logic              swap;
    logic              in_ready_c;
    ecg_sample_t       wr_data;
    ecg_sample_t       ram_q;
    logic              rd_live_p1;
    logic              rd_fv_p1;

    assign accept = (state_q == FILL) && in_valid;

`ifdef ECG_PAIR_AVG_EN
    logic        pair_have_q;
    ecg_sample_t pair_first_q;

    function automatic ecg_sample_t avg_round(input ecg_sample_t a, input ecg_sample_t b);
        logic [ECG_SAMPLE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {{ECG_SAMPLE_W{1'b0}}, 1'b1};
        return sum[ECG_SAMPLE_W:1];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            pair_have_q <= 1'b0;
        end else if (accept) begin
            pair_have_q <= ~pair_have_q;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !pair_have_q) begin
            pair_first_q <= in_data;
        end
    end

    assign store   = accept && pair_have_q;
    assign wr_data = avg_round(pair_first_q, in_data);
`else
    assign store   = accept;
    assign wr_data = in_data;
`endif

    // Next-state and handshake decode
    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b1;
        drop       = 1'b0;
        swap       = 1'b0;
        case (state_q)
            FILL: begin
                in_ready_c = 1'b1;
                if (store && (ptr_q == AW'(DEPTH - 1))) begin
                    state_d = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                in_ready_c = DROP_WHEN_FULL;
                drop       = DROP_WHEN_FULL && in_valid;
                if (frame_start) begin
                    swap    = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FILL;
            ptr_q         <= '0;
            front_bank_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            swap_pulse_q  <= 1'b0;
            overrun_q     <= '0;
        end else begin
            state_q      <= state_d;
            swap_pulse_q <= swap;
            if (store) begin
                ptr_q <= ptr_q + 1'b1;
            end
            if (swap) begin
                front_bank_q  <= ~front_bank_q;
                frame_valid_q <= 1'b1;
            end
            if (drop && (overrun_q != 16'hFFFF)) begin
                overrun_q <= overrun_q + 16'd1;
            end
        end
    end

    ecg_bank_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (ECG_SAMPLE_W)
    ) u_ram (
        .clk   (clk),
        .we    (store),
        .waddr ({~front_bank_q, ptr_q}),
        .wdata (wr_data),
        .raddr ({front_bank_q, rd_addr}),
        .rdata (ram_q)
    );

    // Read stage p1: select qualifiers aligned with the registered RAM output
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_live_p1 <= 1'b0;
            rd_fv_p1   <= 1'b0;
        end else begin
            rd_live_p1 <= 1'b1;
            rd_fv_p1   <= frame_valid_q;
        end
    end

    assign rd_data     = !rd_live_p1 ? '0 : (rd_fv_p1 ? ram_q : MIDLINE);
    assign in_ready    = in_ready_c;
    assign front_bank  = front_bank_q;
    assign frame_valid = frame_valid_q;
    assign swap_pulse  = swap_pulse_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_ecg_sample_writer.sv
// Bench for ecg_sample_writer: back-pressure and drop-mode instances against a bank-level model.
module tb_ecg_sample_writer;

    localparam int DEPTH = 256;
`ifdef ECG_PAIR_AVG_EN
    localparam int NPER = 2;
`else
    localparam int NPER = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic [7:0]  rd_addr = 8'h00;
    logic        in_ready0, in_ready1, fb0, fb1, fv0, fv1, sp0, sp1;
    logic [7:0]  rd0, rd1;
    logic [15:0] ov0, ov1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ecg_sample_writer dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .frame_start(frame_start), .rd_addr(rd_addr), .rd_data(rd0), .front_bank(fb0),
        .frame_valid(fv0), .swap_pulse(sp0), .overrun_cnt(ov0)
    );

    ecg_sample_writer #(.DROP_WHEN_FULL(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .frame_start(frame_start), .rd_addr(rd_addr), .rd_data(rd1), .front_bank(fb1),
        .frame_valid(fv1), .swap_pulse(sp1), .overrun_cnt(ov1)
    );

    // Model: index 0 = back-pressure instance, index 1 = drop instance.
    logic [7:0] m_back  [2][DEPTH];
    logic [7:0] m_front [2][DEPTH];
    int         m_cnt [2];
    int         m_ovr [2];
    bit         m_fv [2], m_fb [2], m_swp [2], m_have [2];
    logic [7:0] m_rd [2], m_first [2];
    bit         m_started = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_cnt[i] = 0; m_ovr[i] = 0; m_fv[i] = 0; m_fb[i] = 0;
                m_swp[i] = 0; m_have[i] = 0; m_rd[i] = 8'h00;
                m_started = 1'b1;
            end else begin
                m_rd[i]  = m_fv[i] ? m_front[i][rd_addr] : 8'h80;
                m_swp[i] = 0;
                if (m_cnt[i] == DEPTH) begin
                    if (i == 1 && in_valid && m_ovr[i] < 65535) m_ovr[i]++;
                    if (frame_start) begin
                        for (int j = 0; j < DEPTH; j++) m_front[i][j] = m_back[i][j];
                        m_cnt[i] = 0;
                        m_fb[i]  = !m_fb[i];
                        m_fv[i]  = 1;
                        m_swp[i] = 1;
                    end
                end else if (in_valid) begin
`ifdef ECG_PAIR_AVG_EN
                    if (!m_have[i]) begin
                        m_first[i] = in_data;
                        m_have[i]  = 1;
                    end else begin
                        m_back[i][m_cnt[i]] = 8'((int'(m_first[i]) + int'(in_data) + 1) / 2);
                        m_cnt[i]++;
                        m_have[i] = 0;
                    end
`else
                    m_back[i][m_cnt[i]] = in_data;
                    m_cnt[i]++;
`endif
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_started) begin
            chk("in_ready0", 32'(in_ready0), (m_cnt[0] == DEPTH) ? 32'd0 : 32'd1);
            chk("in_ready1", 32'(in_ready1), 32'd1);
            chk("front_bank0", 32'(fb0), 32'(m_fb[0]));
            chk("front_bank1", 32'(fb1), 32'(m_fb[1]));
            chk("frame_valid0", 32'(fv0), 32'(m_fv[0]));
            chk("frame_valid1", 32'(fv1), 32'(m_fv[1]));
            chk("swap_pulse0", 32'(sp0), 32'(m_swp[0]));
            chk("swap_pulse1", 32'(sp1), 32'(m_swp[1]));
            chk("overrun0", 32'(ov0), 32'(m_ovr[0]));
            chk("overrun1", 32'(ov1), 32'(m_ovr[1]));
            chk("rd_data0", 32'(rd0), 32'(m_rd[0]));
            chk("rd_data1", 32'(rd1), 32'(m_rd[1]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one raw sample and hold it until the back-pressure instance takes it.
    task automatic push_raw(input logic [7:0] v);
        bit rdy;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (1) begin
            rdy = in_ready0;
            step();
            n++;
            if (rdy) break;
            if (n >= 2000) begin
                chk("push_timeout", 32'd0, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [7:0] v);
        for (int k = 0; k < NPER; k++) push_raw(v);
    endtask

    initial begin
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        chk("lit_fv_after_reset", 32'(fv0), 32'd0);
        chk("lit_ready_after_reset", 32'(in_ready0), 32'd1);

        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 8'(a);
            step();
            chk("lit_midline0", 32'(rd0), 32'h80);
            chk("lit_midline1", 32'(rd1), 32'h80);
        end

        for (int i = 0; i < DEPTH; i++) push(8'(i));
        chk("lit_full_ready0", 32'(in_ready0), 32'd0);
        chk("lit_full_ready1", 32'(in_ready1), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("lit_held_ready0", 32'(in_ready0), 32'd0);
        end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("lit_swap_pulse0", 32'(sp0), 32'd1);
        chk("lit_front_bank0", 32'(fb0), 32'd1);
        chk("lit_overrun1", 32'(ov1), 32'd5);
        step();
        in_valid = 1'b0;
        for (int k = 1; k < NPER; k++) push_raw(8'hA5);
        chk("lit_swap_once", 32'(sp0), 32'd0);
        rd_addr = 8'd37;
        step();
        chk("lit_rd37_0", 32'(rd0), 32'd37);
        chk("lit_rd37_1", 32'(rd1), 32'd37);

        for (int i = 1; i < DEPTH; i++) push(8'(i) ^ 8'h5A);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        rd_addr = 8'd0;
        step();
        chk("lit_held_at_addr0", 32'(rd0), 32'hA5);
        rd_addr = 8'd1;
        step();
        chk("lit_addr1", 32'(rd0), 32'h5B);

        for (int i = 0; i < DEPTH - 1; i++) push(8'(200 - i));
        for (int k = 0; k < NPER - 1; k++) push_raw(8'hEE);
        in_valid    = 1'b1;
        in_data     = 8'hEE;
        frame_start = 1'b1;
        step();
        in_valid    = 1'b0;
        frame_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("lit_no_swap_fb0", 32'(fb0), 32'd0);
        end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("lit_late_swap_fb0", 32'(fb0), 32'd1);
        chk("lit_late_swap_pulse", 32'(sp0), 32'd1);
        rd_addr = 8'd255;
        step();
        chk("lit_rd255", 32'(rd0), 32'hEE);

        for (int i = 0; i < 100; i++) push(8'(i + 1));
        reset = 1'b1;
        step();
        chk("lit_rd_reset", 32'(rd0), 32'd0);
        step();
        reset = 1'b0;
        chk("lit_fv_mid_reset", 32'(fv0), 32'd0);
        chk("lit_ready_mid_reset", 32'(in_ready0), 32'd1);
        rd_addr = 8'd9;
        step();
        chk("lit_midline_again", 32'(rd0), 32'h80);
        for (int i = 0; i < DEPTH; i++) push(8'(i * 7 + 3));
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("lit_fv_refill", 32'(fv0), 32'd1);
        rd_addr = 8'd10;
        step();
        chk("lit_rd10_refill", 32'(rd0), 32'd73);

        for (int c = 0; c < 4000; c++) begin
            in_valid    = ($urandom_range(0, 9) < 6);
            in_data     = 8'($urandom);
            rd_addr     = 8'($urandom);
            frame_start = ($urandom_range(0, 199) == 0);
            reset       = ($urandom_range(0, 2999) == 0);
            step();
        end
        in_valid    = 1'b0;
        frame_start = 1'b0;
        reset       = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecg_sample_writer.md
Name: ecg_sample_writer

Overview:
- Write-side companion to the ECG waveform renderer.
- Accepts a stream of 8-bit ECG samples over a valid/ready handshake and fills a double-buffered 256-entry sample store.
- The back bank is presented to the display reader only at a frame boundary, so each VGA frame renders one coherent, tear-free trace.
- Sits between the sample source (ADC front end or UART loader) and the display reader, which drives rd_addr once per scanline.

Parameters:
- DEPTH, 256, samples per bank; power of two; address width is log2(DEPTH).
- DROP_WHEN_FULL, 0: when 0, back-pressure via in_ready; when 1, in_ready is held at 1 and samples arriving while waiting for swap are discarded and counted.
- MIDLINE, 8'h80, value returned on rd_data before the first swap.

Ports:
- clk  in  1  system clock (pixel clock domain).
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  sample offered.
- in_ready  out  1  writer can accept a sample.
- in_data  in  8  ECG sample, unsigned 0–255.
- frame_start  in  1  one-cycle pulse from VGA timing at the start of vertical blank.
- rd_addr  in  8  display read index.
- rd_data  out  8  sample at rd_addr from the front bank; registered, 1-cycle latency.
- front_bank  out  1  bank currently displayed.
- frame_valid  out  1  high once at least one swap has occurred.
- swap_pulse  out  1  one-cycle pulse in the cycle after a swap.
- overrun_cnt  out  16  saturating count of discarded samples (DROP_WHEN_FULL=1 only; otherwise held at 0).

Behaviour:
- Reset values:
  - state FILL, write pointer 0, front_bank 0.
  - frame_valid 0, swap_pulse 0, overrun_cnt 0, rd_data 0.
  - in_ready is 1 after reset.
  - RAM contents are not reset.
- Handshake:
  - A transfer occurs when in_valid && in_ready on a rising clk edge.
  - in_data is written to back bank (~front_bank) at the write pointer, and the pointer increments.
  - in_valid may be held with data stable; there is no combinational path from in_valid to in_ready.
- State FILL:
  - in_ready = 1.
  - When the transfer at pointer DEPTH-1 is accepted, the pointer wraps to 0 and the state goes to WAIT_SWAP.
  - frame_start while in FILL is ignored; partial banks are never shown.
- State WAIT_SWAP:
  - in_ready = 0 when DROP_WHEN_FULL=0.
  - When DROP_WHEN_FULL=1: in_ready = 1; each in_valid cycle increments overrun_cnt, saturating at 16'hFFFF; no RAM write.
  - On frame_start: front_bank toggles, frame_valid is set to 1, swap_pulse is 1 on the next cycle, and the state goes to FILL.
- Simultaneous final write and frame_start in FILL:
  - The write completes.
  - No swap occurs this frame; the swap waits for the next frame_start.
- Read path:
  - rd_data <= frame_valid ? mem[front_bank][rd_addr] : MIDLINE, one cycle after rd_addr.
  - The bank select uses the registered front_bank, so a read issued in the swap cycle returns old-bank data.
  - A read and write to the same address never collide, because the banks are disjoint.
- Reset mid-fill:
  - All progress is abandoned.
  - frame_valid returns to 0 and the display shows MIDLINE until the next completed bank swaps.

Optional Feature:
- Macro ECG_PAIR_AVG_EN.
- Defined:
  - Input samples are consumed in pairs; the stored value is (a+b+1)>>1, computed with a 9-bit intermediate.
  - The pointer advances once per pair, halving the effective sample rate.
  - A held first sample of a pair is discarded on reset.
  - In WAIT_SWAP, back-pressure and drop rules apply per raw sample.
- Undefined: each accepted sample is stored directly.

Decomposition:
- Package ecg_pkg holds:
  - ECG_SAMPLE_W = 8 and ECG_DEPTH = 256.
  - ECG_MIDLINE.
  - typedef ecg_sample_t.
  - enum wr_state_t {FILL, WAIT_SWAP}.
- Sub-module ecg_bank_ram: simple dual-port 2×DEPTH×8 RAM, one write port, one registered read port, addressed by {bank, addr}.
- Control FSM, pointer, averaging and counters live in ecg_sample_writer.

Test Plan:
1. After reset, rd_addr=0..255 -> rd_data=8'h80, frame_valid=0, in_ready=1.
2. Stream 256 samples value=index, then pulse frame_start:
   - swap_pulse fires once and front_bank=1.
   - rd_addr=37 returns 37 one cycle later.
3. With DROP_WHEN_FULL=0, offer a 257th sample before frame_start:
   - in_ready=0 and the sample is held.
   - After frame_start it is accepted into bank 0 at address 0.
4. With DROP_WHEN_FULL=1, offer 5 samples in WAIT_SWAP -> overrun_cnt=5 and bank contents unchanged after swap.
5. Final (256th) write coincident with frame_start -> no swap; the swap occurs on the next frame_start.
6. Assert reset after 100 writes -> frame_valid=0 and ptr=0; refilling 256 samples and swapping shows only the new data.
   - With ECG_PAIR_AVG_EN, inputs 10,13 store 12.
